// File: rtl/prim_util_pkg.sv
//------------------------------------------------------------------------------
// prim_util_pkg : shared sizing helpers for primitive blocks
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package prim_util_pkg;

  // Bits needed to index `value` items; a single item still needs one bit.
  function automatic integer vbits(integer value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tl_rr_pick.sv
//------------------------------------------------------------------------------
// tl_rr_pick : combinational rotate-priority picker, one-hot grant
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tl_rr_pick
  import prim_util_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = vbits(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Scan upward from the pointer, wrapping at N-1, and take the first request.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(i_ptr) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tl_req_scheduler.sv
//------------------------------------------------------------------------------
// tl_req_scheduler : credit-limited, burst-locking round-robin A-channel arbiter
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tl_req_scheduler
  import prim_util_pkg::*;
#(
  parameter  int NumLinks       = 2,
  parameter  int MaxOutstanding = 4,
  localparam int LinkWidth      = vbits(NumLinks),
  localparam int CntWidth       = vbits(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NumLinks-1:0]  req_valid_i,
  input  logic                 dev_ready_i,
  input  logic                 req_first_i,
  input  logic                 req_last_i,
  output logic                 dev_valid_o,
  output logic [NumLinks-1:0]  grant_o,
  output logic [NumLinks-1:0]  host_ready_o,
  input  logic                 rsp_done_i,
  input  logic [LinkWidth-1:0] rsp_link_i,
  output logic [NumLinks-1:0]  credit_full_o,
  output logic                 locked_o,
  output logic                 err_o
);

  localparam logic [CntWidth-1:0] c_max = CntWidth'(MaxOutstanding);

  logic                 r_locked;
  logic [NumLinks-1:0]  r_sel;
  logic [LinkWidth-1:0] r_ptr;
  logic [CntWidth-1:0]  r_cnt [NumLinks];
  logic                 r_err;

  logic [NumLinks-1:0]  w_elig;
  logic [NumLinks-1:0]  w_pick;
  logic [NumLinks-1:0]  w_grant;
  logic [LinkWidth-1:0] w_grant_idx;
  logic [LinkWidth-1:0] w_ptr_next;
  logic                 w_accept;
  logic                 w_rsp_ok;
  logic [NumLinks-1:0]  w_inc;
  logic [NumLinks-1:0]  w_dec;
  logic [NumLinks-1:0]  w_uflow;

  for (genvar i = 0; i < NumLinks; i++) begin : g_link
    assign w_elig[i]        = req_valid_i[i] && (r_cnt[i] < c_max);
    assign credit_full_o[i] = (r_cnt[i] == c_max);
    assign w_inc[i]         = w_accept && req_first_i && w_grant[i];
    assign w_dec[i]         = rsp_done_i && w_rsp_ok && (int'(rsp_link_i) == i);
    assign w_uflow[i]       = w_dec[i] && !w_inc[i] && (r_cnt[i] == '0);
  end

  tl_rr_pick #(
    .N  (NumLinks),
    .PW (LinkWidth)
  ) u_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  // A held burst keeps its link regardless of that link's credit state.
  assign w_grant      = r_locked ? r_sel : w_pick;
  assign grant_o      = w_grant;
  assign dev_valid_o  = |(w_grant & req_valid_i);
  assign host_ready_o = w_grant & {NumLinks{dev_ready_i}};
  assign w_accept     = dev_valid_o && dev_ready_i;
  assign w_rsp_ok     = int'(rsp_link_i) < NumLinks;
  assign locked_o     = r_locked;
  assign err_o        = r_err;

  always_comb begin
    w_grant_idx = '0;
    for (int i = 0; i < NumLinks; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = LinkWidth'(i);
      end
    end
  end

  assign w_ptr_next = (int'(w_grant_idx) == NumLinks - 1) ? '0 : w_grant_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_locked <= 1'b0;
      r_sel    <= '0;
      r_ptr    <= '0;
    end else if (w_accept) begin
      if (req_last_i) begin
        r_locked <= 1'b0;
        r_ptr    <= w_ptr_next;
      end else begin
        r_locked <= 1'b1;
        r_sel    <= w_grant;
      end
    end
  end

  // Same-link increment and decrement cancel; an empty counter never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumLinks; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumLinks; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec[i] && !w_inc[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if ((|w_uflow) || (rsp_done_i && !w_rsp_ok)) begin
      r_err <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tl_req_scheduler.sv
//------------------------------------------------------------------------------
// tb_tl_req_scheduler : directed self-checking bench for tl_req_scheduler
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_tl_req_scheduler;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] req_valid_i;
  logic       dev_ready_i;
  logic       req_first_i;
  logic       req_last_i;
  logic       dev_valid_o;
  logic [1:0] grant_o;
  logic [1:0] host_ready_o;
  logic       rsp_done_i;
  logic [0:0] rsp_link_i;
  logic [1:0] credit_full_o;
  logic       locked_o;
  logic       err_o;

  int n_checks = 0;
  int n_errors = 0;

  tl_req_scheduler #(
    .NumLinks       (2),
    .MaxOutstanding (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_valid_i   (req_valid_i),
    .dev_ready_i   (dev_ready_i),
    .req_first_i   (req_first_i),
    .req_last_i    (req_last_i),
    .dev_valid_o   (dev_valid_o),
    .grant_o       (grant_o),
    .host_ready_o  (host_ready_o),
    .rsp_done_i    (rsp_done_i),
    .rsp_link_i    (rsp_link_i),
    .credit_full_o (credit_full_o),
    .locked_o      (locked_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic rdy, input logic f, input logic l,
                       input logic rd, input logic rl);
    req_valid_i = v;
    dev_ready_i = rdy;
    req_first_i = f;
    req_last_i  = l;
    rsp_done_i  = rd;
    rsp_link_i  = rl;
    #1;
  endtask

  // Advance past one rising edge; inputs change 2 time units after it.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    rst_i = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_full", 32'(credit_full_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);

    // Round-robin with single-beat messages on both links
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("rr_grant", 32'(grant_o), 32'(rr_exp[i]));
      check("rr_hready", 32'(host_ready_o), 32'(rr_exp[i]));
      tick();
    end
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rr_cnt0", 32'(dut.r_cnt[0]), 32'd2);
    check("rr_cnt1", 32'(dut.r_cnt[1]), 32'd2);

    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("drain_cnt0", 32'(dut.r_cnt[0]), 32'd0);
    check("drain_cnt1", 32'(dut.r_cnt[1]), 32'd0);
    check("drain_err", 32'(err_o), 32'd0);

    // Four-beat burst on link1 with link0 joining at beat 2 and a stall
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("b1_grant", 32'(grant_o), 32'b10);
    check("b1_locked", 32'(locked_o), 32'd0);
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b2_grant", 32'(grant_o), 32'b10);
    check("b2_locked", 32'(locked_o), 32'd1);
    check("b2_dvalid", 32'(dev_valid_o), 32'd1);
    tick();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("stall_grant", 32'(grant_o), 32'b10);
    check("stall_hready", 32'(host_ready_o), 32'b00);
    check("stall_dvalid", 32'(dev_valid_o), 32'd1);
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("b3_grant", 32'(grant_o), 32'b10);
    check("b3_locked", 32'(locked_o), 32'd1);
    tick();
    drive(2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("b4_grant", 32'(grant_o), 32'b10);
    check("b4_locked", 32'(locked_o), 32'd1);
    tick();
    drive(2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_grant", 32'(grant_o), 32'b01);
    check("post_locked", 32'(locked_o), 32'd0);
    check("post_cnt1", 32'(dut.r_cnt[1]), 32'd1);
    tick();

    // Reset in the middle of a burst on link1
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rb1_grant", 32'(grant_o), 32'b10);
    tick();
    rst_i = 1'b1;
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rb2_locked", 32'(locked_o), 32'd1);
    tick();
    rst_i = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rr2_locked", 32'(locked_o), 32'd0);
    check("rr2_cnt0", 32'(dut.r_cnt[0]), 32'd0);
    check("rr2_cnt1", 32'(dut.r_cnt[1]), 32'd0);
    check("rr2_grant", 32'(grant_o), 32'b01);

    // Credit cap on link0
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("cap_grant", 32'(grant_o), 32'b01);
      tick();
    end
    drive(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("cap_full", 32'(credit_full_o), 32'b01);
    check("cap_dvalid", 32'(dev_valid_o), 32'd0);
    check("cap_grant0", 32'(grant_o), 32'b00);
    tick();
    drive(2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("free_grant", 32'(grant_o), 32'b01);
    check("free_dvalid", 32'(dev_valid_o), 32'd1);
    check("free_full", 32'(credit_full_o), 32'b00);
    tick();

    // Full link0 stays granted while locked; same-link inc and dec cancel
    drive(2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sim_full", 32'(credit_full_o), 32'b01);
    check("sim_locked", 32'(locked_o), 32'd1);
    check("sim_grant", 32'(grant_o), 32'b01);
    tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sim_cnt0", 32'(dut.r_cnt[0]), 32'd4);
    check("sim_unlock", 32'(locked_o), 32'd0);

    // Increment on link1 with a response on link0 in the same cycle
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("x_grant", 32'(grant_o), 32'b10);
    tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("x_cnt1", 32'(dut.r_cnt[1]), 32'd1);
    check("x_cnt0", 32'(dut.r_cnt[0]), 32'd3);

    // Underflow on link1 sets the sticky error
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("uf_cnt1a", 32'(dut.r_cnt[1]), 32'd0);
    check("uf_err_a", 32'(err_o), 32'd0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("uf_cnt1b", 32'(dut.r_cnt[1]), 32'd0);
    check("uf_err_b", 32'(err_o), 32'd1);
    tick();
    tick();
    tick();
    check("uf_sticky", 32'(err_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check("uf_rst", 32'(err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tl_req_scheduler.md
# tl_req_scheduler

Credit-limited, burst-aware round-robin scheduler for the A (request) channel of a TileLink host-to-device socket. It chooses which host link may drive the shared device A channel, holds that choice for a whole multi-beat burst, and caps each link's in-flight messages at `MaxOutstanding` by counting A first beats against completed D responses. It sits beside the socket's A-channel mux, which uses `grant_o` as its select, and is fed by the device-side burst tracker and the D-channel routing logic.

## Interface
- `NumLinks`, 2, number of host links competing for channel A.
- `MaxOutstanding`, 4, maximum unanswered A messages per link (≥1).
- `LinkWidth`, localparam `vbits(NumLinks)`, link index width.
- `CntWidth`, localparam `vbits(MaxOutstanding+1)`, per-link counter width.

- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  NumLinks  per-link host A valid.
- `dev_ready_i`  in  1  device A ready.
- `req_first_i`  in  1  current device A beat is the first of its message.
- `req_last_i`  in  1  current device A beat is the last of its message.
- `dev_valid_o`  out  1  muxed device A valid.
- `grant_o`  out  NumLinks  one-hot (or zero) mux select.
- `host_ready_o`  out  NumLinks  per-link A ready.
- `rsp_done_i`  in  1  pulse: last D beat of a response accepted by a host.
- `rsp_link_i`  in  LinkWidth  link that received that response.
- `credit_full_o`  out  NumLinks  link at `MaxOutstanding`.
- `locked_o`  out  1  mid-burst lock held.
- `err_o`  out  1  sticky: response seen for a link with zero count.

## Operation
- State: `locked`, `sel[NumLinks]`, round-robin pointer `ptr[LinkWidth]`, `cnt[i]` per link, `err`.
- Eligibility: `elig[i] = req_valid_i[i] && cnt[i] < MaxOutstanding`.
- Unlocked: `grant_o` = first set bit of `elig` scanning from `ptr` upward, wrapping at `NumLinks-1`→0. Zero if none eligible.
- Locked: `grant_o = sel`; credits are not re-checked.
- `dev_valid_o = |(grant_o & req_valid_i)`; `host_ready_o[i] = grant_o[i] && dev_ready_i`.
- Accept = `dev_valid_o && dev_ready_i`.
- On accept with `!req_last_i`: `locked<=1`, `sel<=grant_o`.
- On accept with `req_last_i`: `locked<=0`, `ptr<=(index of grant_o)+1` modulo `NumLinks`.
- On accept with `req_first_i`: `cnt[granted]` +1.
- `rsp_done_i`: `cnt[rsp_link_i]` −1. If the count is 0, it stays 0 and `err<=1`.
- Increment and decrement on the same link in the same cycle: no change. On different links: both apply.
- A single-beat message (first && last) increments the count and advances `ptr`; it never locks.
- `rsp_link_i ≥ NumLinks`: ignored and sets `err`.
- `credit_full_o[i] = (cnt[i] == MaxOutstanding)`; `locked_o = locked`; `err_o = err`.

## Timing
- `grant_o`, `dev_valid_o` and `host_ready_o` are combinational from inputs and state, with zero-cycle latency. `host_ready_o` may depend on valid. No valid depends on ready.
- The lock, pointer and counter effects of a beat are visible in the cycle after the accept.
- A freed credit (`rsp_done_i` in cycle N) makes the link eligible in cycle N+1.
- Reset (`rst_i` high at a clock edge): `locked=0`, `sel=0`, `ptr=0`, all `cnt=0`, `err=0`.
  - Resulting outputs: `locked_o=0`, `err_o=0`, `credit_full_o=0`. `grant_o` is whatever the combinational logic computes from `ptr=0`; it is 0 with no valids.
  - Reset mid-burst abandons the lock and all counts. Hosts are reset together with the scheduler.
- A stalled locked burst (valid high, ready low) holds `grant_o` indefinitely.

## Structure
- Imports `prim_util_pkg` for `vbits`. No new shared typedefs or constants are needed.
- One sub-module: `tl_rr_pick`. It is a combinational rotate-priority encoder with inputs `req[N]` and `ptr`, and output one-hot `gnt[N]`.
- Counters, lock and pointer live in `tl_req_scheduler`.

## Test plan
- **Round-robin, single-beat:** both links valid for 4 cycles, ready=1, first=last=1 → grants 0,1,0,1, and each `cnt` ends at 2.
- **Burst lock:** link1 sends a 4-beat burst while link0 raises valid at beat 2 → `grant_o=2'b10` for all 4 beats and `locked_o=1` on beats 2–4. Link0 is granted on the next cycle.
- **Credit cap:** `MaxOutstanding=4`, link0 only, 4 single-beat messages → `credit_full_o[0]=1`; a fifth valid gives `dev_valid_o=0`. Then `rsp_done_i` with link 0 → granted one cycle later.
- **Simultaneous:** with `cnt[0]=4`, an accept on link0 (counts may differ only mid-lock) plus `rsp_done_i` link0 in the same cycle → `cnt[0]` stays 4. Separately, a first beat on link1 plus a response on link0 → `cnt[1]` +1 and `cnt[0]` −1.
- **Underflow:** `rsp_done_i` link1 with `cnt[1]=0` → `cnt[1]=0` and `err_o=1` until reset.
- **Reset mid-burst:** assert `rst_i` on beat 2 of 4 → next cycle `locked_o=0`, counts 0, and link0 is preferred.
